// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared CSR addresses, address type and mstatus/mie field constants
package common;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MISA      = 12'h301;
    localparam csr_addr_t CSR_MIE       = 12'h304;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MTVAL     = 12'h343;
    localparam csr_addr_t CSR_MIP       = 12'h344;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_CYCLE     = 12'hC00;
    localparam csr_addr_t CSR_INSTRET   = 12'hC02;
    localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
    localparam csr_addr_t CSR_INSTRETH  = 12'hC82;
    localparam csr_addr_t CSR_MVENDORID = 12'hF11;
    localparam csr_addr_t CSR_MARCHID   = 12'hF12;
    localparam csr_addr_t CSR_MIMPID    = 12'hF13;
    localparam csr_addr_t CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK      = 32'h0000_0888;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with per-half load; a load suppresses the increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR storage, trap/mret updates, trap vector; counters under CSR_COUNTERS_EN
module csr_file
    import common::*;
#(
    parameter int          HART_ID     = 0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    input  csr_addr_t   csr_addr,
    output logic [31:0] csr_data,
    input  logic        csr_wb_en,
    input  logic [31:0] csr_next,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_valid,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);

    logic        st_mie;
    logic        st_mpie;
    logic [2:0]  mie_bits;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mapped;
    logic        read_only;
    logic        wr;

    assign read_only = (csr_addr[11:10] == 2'b11);
    // Trap and mret both pre-empt a same-cycle CSR write, including counter loads.
    assign wr = csr_wb_en && !trap_valid && !mret_valid && !read_only;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mie_bits <= '0;
            mtvec    <= RESET_MTVEC & ~32'h2;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (trap_valid) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            mepc    <= trap_pc & ~32'h3;
            mcause  <= trap_cause;
            mtval   <= trap_val;
        end else if (mret_valid) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie  <= csr_next[MSTATUS_MIE];
                    st_mpie <= csr_next[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_bits <= {csr_next[11], csr_next[7], csr_next[3]};
                CSR_MTVEC:    mtvec    <= csr_next & ~32'h2;
                CSR_MSCRATCH: mscratch <= csr_next;
                CSR_MEPC:     mepc     <= csr_next & ~32'h3;
                CSR_MCAUSE:   mcause   <= csr_next;
                CSR_MTVAL:    mtval    <= csr_next;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    csr_counter64 u_cycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr && csr_addr == CSR_MCYCLE),
        .wr_hi (wr && csr_addr == CSR_MCYCLEH),
        .wdata (csr_next),
        .count (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .wr_lo (wr && csr_addr == CSR_MINSTRET),
        .wr_hi (wr && csr_addr == CSR_MINSTRETH),
        .wdata (csr_next),
        .count (instret_cnt)
    );
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

    always_comb begin
        csr_data = '0;
        mapped   = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:  csr_data = MSTATUS_MPP_M
                                   | (32'(st_mpie) << MSTATUS_MPIE)
                                   | (32'(st_mie) << MSTATUS_MIE);
            CSR_MISA:     csr_data = MISA_VALUE;
            CSR_MIE:      csr_data = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0} & MIE_MASK;
            CSR_MTVEC:    csr_data = mtvec;
            CSR_MSCRATCH: csr_data = mscratch;
            CSR_MEPC:     csr_data = mepc;
            CSR_MCAUSE:   csr_data = mcause;
            CSR_MTVAL:    csr_data = mtval;
            CSR_MIP:      csr_data = '0;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_data = '0;
            CSR_MHARTID:  csr_data = 32'(HART_ID);
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    csr_data = cycle_cnt[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   csr_data = cycle_cnt[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  csr_data = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_data = instret_cnt[63:32];
`else
            // Counters absent: machine counter addresses stay legal and read zero.
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_data = '0;
`endif
            default: mapped = 1'b0;
        endcase
    end

    assign csr_illegal = csr_valid && (!mapped || (csr_wb_en && read_only));

    // Vectored mode: interrupt causes offset the base; bit 31 shifts out of the sum.
    assign trap_vector = (mtvec[0] && trap_cause[31])
                       ? ({mtvec[31:2], 2'b00} + (trap_cause << 2))
                       : {mtvec[31:2], 2'b00};
    assign mepc_out = mepc;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file (counter checks under CSR_COUNTERS_EN)
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        csr_wb_en;
    logic [31:0] csr_next;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_valid;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_file #(.HART_ID(5), .RESET_MTVEC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_valid    (csr_valid),
        .csr_addr     (csr_addr),
        .csr_data     (csr_data),
        .csr_wb_en    (csr_wb_en),
        .csr_next     (csr_next),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret_valid   (mret_valid),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_valid = 1'b1;
        csr_addr  = a;
        csr_next  = d;
        csr_wb_en = 1'b1;
        tick();
        csr_valid = 1'b0;
        csr_wb_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_data, exp);
    endtask

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_addr = '0; csr_wb_en = 1'b0; csr_next = '0;
        instr_retire = 1'b0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0;
        trap_val = '0; mret_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        read_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        read_chk("misa", 12'h301, 32'h4000_0100);
        read_chk("rst_mtvec", 12'h305, 32'h0000_0000);
        read_chk("rst_mepc", 12'h341, 32'h0000_0000);
        read_chk("mhartid", 12'hF14, 32'h0000_0005);
        csr_valid = 1'b1;
        read_chk("unmapped_data", 12'h7C0, 32'h0);
        check("unmapped_illegal", 32'(csr_illegal), 32'h1);
        csr_addr = 12'hF14;
        #1;
        check("ro_read_legal", 32'(csr_illegal), 32'h0);
        csr_valid = 1'b0;

        csr_write(12'h305, 32'h8000_0003);
        read_chk("mtvec_warl", 12'h305, 32'h8000_0001);
        trap_cause = 32'h8000_0007;
        #1;
        check("vec_irq", trap_vector, 32'h8000_001C);
        trap_cause = 32'h0000_0007;
        #1;
        check("vec_exc", trap_vector, 32'h8000_0000);

        csr_write(12'h300, 32'hFFFF_E008);
        read_chk("mstatus_mie", 12'h300, 32'h0000_1808);
        trap_valid = 1'b1; trap_pc = 32'h0000_0104; trap_cause = 32'h0000_000B; trap_val = 32'h55;
        csr_wb_en = 1'b1; csr_addr = 12'h341; csr_next = 32'hDEAD_0000;
        tick();
        trap_valid = 1'b0; csr_wb_en = 1'b0;
        check("trap_mepc_out", mepc_out, 32'h0000_0104);
        read_chk("trap_mepc", 12'h341, 32'h0000_0104);
        read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        read_chk("trap_mcause", 12'h342, 32'h0000_000B);
        read_chk("trap_mtval", 12'h343, 32'h0000_0055);

        mret_valid = 1'b1; csr_wb_en = 1'b1; csr_addr = 12'h300; csr_next = 32'h0;
        tick();
        mret_valid = 1'b0; csr_wb_en = 1'b0;
        read_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        csr_write(12'h341, 32'h0000_0123);
        read_chk("mepc_warl", 12'h341, 32'h0000_0120);
        check("mepc_out", mepc_out, 32'h0000_0120);
        csr_write(12'h304, 32'hFFFF_FFFF);
        read_chk("mie_warl", 12'h304, 32'h0000_0888);
        csr_write(12'h344, 32'hFFFF_FFFF);
        read_chk("mip_zero", 12'h344, 32'h0);

        csr_write(12'h340, 32'h0000_00A5);
        csr_valid = 1'b1; csr_wb_en = 1'b1; csr_addr = 12'h340; csr_next = 32'h0000_005A;
        #1;
        check("pre_edge_read", csr_data, 32'h0000_00A5);
        tick();
        csr_valid = 1'b0; csr_wb_en = 1'b0;
        read_chk("post_edge_read", 12'h340, 32'h0000_005A);

        csr_valid = 1'b1; csr_wb_en = 1'b1; csr_addr = 12'hF14; csr_next = 32'h77;
        #1;
        check("ro_write_illegal", 32'(csr_illegal), 32'h1);
        tick();
        csr_valid = 1'b0; csr_wb_en = 1'b0;
        read_chk("ro_unchanged", 12'hF14, 32'h0000_0005);

`ifdef CSR_COUNTERS_EN
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0000_0000);
        tick();
        tick();
        read_chk("mcycle_lo", 12'hB00, 32'h0000_0001);
        read_chk("mcycle_hi", 12'hB80, 32'h0000_0001);
        read_chk("cycle_hi_alias", 12'hC80, 32'h0000_0001);
        instr_retire = 1'b1;
        csr_write(12'hB02, 32'h0000_0005);
        instr_retire = 1'b0;
        read_chk("minstret_wr", 12'hB02, 32'h0000_0005);
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        read_chk("instret_alias", 12'hC02, 32'h0000_0006);
        read_chk("minstreth", 12'hB82, 32'h0000_0000);
`else
        for (int i = 0; i < 10; i++) tick();
        csr_valid = 1'b1;
        read_chk("nocnt_mcycle", 12'hB00, 32'h0);
        check("nocnt_legal", 32'(csr_illegal), 32'h0);
        csr_addr = 12'hC00;
        #1;
        check("nocnt_cycle_illegal", 32'(csr_illegal), 32'h1);
        csr_valid = 1'b0;
        csr_write(12'hB02, 32'h1234);
        read_chk("nocnt_minstret", 12'hB02, 32'h0);
`endif

        rst = 1'b1; trap_valid = 1'b1; trap_pc = 32'h0000_0200;
        csr_wb_en = 1'b1; csr_addr = 12'h340; csr_next = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; trap_valid = 1'b0; csr_wb_en = 1'b0;
        read_chk("midrst_mstatus", 12'h300, 32'h0000_1800);
        read_chk("midrst_mepc", 12'h341, 32'h0);
        read_chk("midrst_mscratch", 12'h340, 32'h0);
        read_chk("midrst_mtvec", 12'h305, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
